// File: rtl/reg_writeback_arbiter_pkg.sv
// Shared widths and the writeback entry type for the register-file write port arbiter.
package reg_writeback_arbiter_pkg;

  localparam int REG_AW_DEF     = 5;
  localparam int DATA_W_DEF     = 32;
  localparam int FIFO_DEPTH_DEF = 4;
  localparam int STARVE_MAX_DEF = 8;

  // Entry at the default widths; the top re-declares it locally when widths are overridden.
  typedef struct packed {
    logic [REG_AW_DEF-1:0]  reg_num;
    logic [DATA_W_DEF-1:0]  data;
  } wb_entry_t;

endpackage

// File: rtl/reg_writeback_arbiter_fifo.sv
// Synchronous circular FIFO holding long-latency results until a write slot frees up.
// Pointers carry one extra wrap bit; the occupancy count is registered so full/empty are glitch-free.
module reg_writeback_arbiter_fifo #(
  parameter int WIDTH = 37,
  parameter int DEPTH = 4
) (
  input  logic                       clk,
  input  logic                       reset,
  input  logic                       push,
  input  logic [WIDTH-1:0]           push_data,
  input  logic                       pop,
  output logic [WIDTH-1:0]           head,
  output logic                       full,
  output logic                       empty,
  output logic [$clog2(DEPTH):0]     count
);

  localparam int AW = $clog2(DEPTH);

  logic [WIDTH-1:0] mem [DEPTH];
  logic [AW:0]      wr_ptr;
  logic [AW:0]      rd_ptr;
  logic             do_push;
  logic             do_pop;

  assign full    = (count == (AW+1)'(DEPTH));
  assign empty   = (count == '0);
  assign do_push = push && !full;
  assign do_pop  = pop && !empty;
  assign head    = mem[rd_ptr[AW-1:0]];

  // Pointer and occupancy bookkeeping; simultaneous push and pop leaves count unchanged.
  always_ff @(posedge clk) begin
    if (reset) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else begin
      if (do_push) wr_ptr <= wr_ptr + 1'b1;
      if (do_pop)  rd_ptr <= rd_ptr + 1'b1;
      case ({do_push, do_pop})
        2'b10:   count <= count + 1'b1;
        2'b01:   count <= count - 1'b1;
        default: count <= count;
      endcase
    end
  end

  // Storage array; contents need no reset because the pointers gate visibility.
  always_ff @(posedge clk) begin
    if (do_push) mem[wr_ptr[AW-1:0]] <= push_data;
  end

endmodule

// File: rtl/reg_writeback_arbiter.sv
// Owns the register file write port: pipeline writebacks win, queued long-latency results
// fill idle slots in order. Tracks pending long-latency destinations and raises drain_req
// when the queue head has waited too long so the hazard unit can open a bubble.
module reg_writeback_arbiter
  import reg_writeback_arbiter_pkg::*;
#(
  parameter int DATA_W     = DATA_W_DEF,
  parameter int REG_AW     = REG_AW_DEF,
  parameter int FIFO_DEPTH = FIFO_DEPTH_DEF,
  parameter int STARVE_MAX = STARVE_MAX_DEF
) (
  input  logic                   clk,
  input  logic                   reset,
  input  logic                   wb_valid,
  input  logic [REG_AW-1:0]      wb_reg,
  input  logic [DATA_W-1:0]      wb_data,
  input  logic                   lu_valid,
  output logic                   lu_ready,
  input  logic [REG_AW-1:0]      lu_reg,
  input  logic [DATA_W-1:0]      lu_data,
  input  logic                   iss_valid,
  input  logic [REG_AW-1:0]      iss_reg,
  output logic [2**REG_AW-1:0]   pending,
  output logic                   drain_req,
  output logic                   Write_Enable,
  output logic [REG_AW-1:0]      Write_Reg_Num,
  output logic [DATA_W-1:0]      Write_Data
);

  localparam int ENTRY_W = REG_AW + DATA_W;
  localparam int CNT_W   = $clog2(FIFO_DEPTH) + 1;
  localparam int AGE_W   = $clog2(STARVE_MAX + 1);

  typedef struct packed {
    logic [REG_AW-1:0] reg_num;
    logic [DATA_W-1:0] data;
  } entry_t;

  entry_t              push_entry;
  entry_t              head_entry;
  logic [ENTRY_W-1:0]  head_raw;
  logic                q_full;
  logic                q_empty;
  logic [CNT_W-1:0]    q_count;
  logic                push;
  logic                pop;
  logic                q_waiting;
  logic [AGE_W-1:0]    age_q;
  logic [AGE_W-1:0]    age_nxt;
  logic [2**REG_AW-1:0] pending_nxt;

  assign push_entry = '{reg_num: lu_reg, data: lu_data};
  assign head_entry = entry_t'(head_raw);

  // Held low during reset so the producer never hands off into a queue being cleared.
  assign lu_ready  = !reset && !q_full;
  assign push      = lu_valid && lu_ready;
  assign pop       = !reset && !wb_valid && !q_empty;
  assign q_waiting = (q_count != '0) && !pop;

  reg_writeback_arbiter_fifo #(
    .WIDTH (ENTRY_W),
    .DEPTH (FIFO_DEPTH)
  ) u_fifo (
    .clk       (clk),
    .reset     (reset),
    .push      (push),
    .push_data (push_entry),
    .pop       (pop),
    .head      (head_raw),
    .full      (q_full),
    .empty     (q_empty),
    .count     (q_count)
  );

  // Registered write port: pipeline first, then queue head; reg 0 never gets an enable.
  always_ff @(posedge clk) begin
    if (reset) begin
      Write_Enable  <= 1'b0;
      Write_Reg_Num <= '0;
      Write_Data    <= '0;
    end else if (wb_valid) begin
      Write_Enable  <= (wb_reg != '0);
      Write_Reg_Num <= wb_reg;
      Write_Data    <= wb_data;
    end else if (pop) begin
      Write_Enable  <= (head_entry.reg_num != '0);
      Write_Reg_Num <= head_entry.reg_num;
      Write_Data    <= head_entry.data;
    end else begin
      Write_Enable  <= 1'b0;
    end
  end

  // Scoreboard next state: clear on pop, then set on issue so a same-cycle set wins.
  always_comb begin
    pending_nxt = pending;
    if (pop) pending_nxt[head_entry.reg_num] = 1'b0;
    if (iss_valid && (iss_reg != '0)) pending_nxt[iss_reg] = 1'b1;
    pending_nxt[0] = 1'b0;
  end

  // Scoreboard register.
  always_ff @(posedge clk) begin
    if (reset) pending <= '0;
    else       pending <= pending_nxt;
  end

  // Head age: counts stalled cycles, clears on pop or empty, saturates at the threshold.
  always_comb begin
    age_nxt = '0;
    if (q_waiting) begin
      if (age_q < AGE_W'(STARVE_MAX)) age_nxt = age_q + 1'b1;
      else                            age_nxt = age_q;
    end
  end

  // Age counter and its registered threshold flag move together, so drain_req drops right after a pop.
  always_ff @(posedge clk) begin
    if (reset) begin
      age_q     <= '0;
      drain_req <= 1'b0;
    end else begin
      age_q     <= age_nxt;
      drain_req <= (age_nxt >= AGE_W'(STARVE_MAX));
    end
  end

endmodule
